mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit of the 5-stage RISC-V pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Takes load/store controls, address and store data from EX/MEM, and runs a req/ack handshake to a word-organised data memory with byte enables.
- Formats load data (sign/zero extension, byte/half lane select) into readMem_o, which feeds the MEM/WB readMem input.
- Drives stall_o to freeze the upstream pipeline until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles in REQ without dmem_ack_i before the access is abandoned (range 1..255).
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  input  1  clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read_i  input  1  load in MEM stage.
- mem_write_i  input  1  store in MEM stage.
- funct3_i  input  3  RISC-V load/store funct3.
- addr_i  input  32  byte address (ALU result).
- wdata_i  input  32  store data (rs2).
- dmem_req_o  output  1  memory request.
- dmem_we_o  output  1  1 = write.
- dmem_addr_o  output  32  word address {addr_i[31:2],2'b00}.
- dmem_be_o  output  4  byte enables.
- dmem_wdata_o  output  32  lane-replicated store data.
- dmem_ack_i  input  1  memory completion; rdata valid in the same cycle.
- dmem_rdata_i  input  32  memory read word.
- readMem_o  output  32  formatted load result, registered.
- stall_o  output  1  freeze PC/IF/ID/EX/MEM registers.
- access_fault_o  output  1  misaligned or illegal access, combinational.
- timeout_o  output  1  sticky; set when any access times out.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; counter = 0.
  - readMem_o = 0; timeout_o = 0; dmem_req_o = 0.
  - Reset during REQ drops the request at once. The memory must tolerate an abandoned request.
- access = mem_read_i | mem_write_i.
- fault = any of:
  - mem_read_i & mem_write_i both set;
  - funct3 not legal for the operation. Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010;
  - half access with addr_i[0] = 1;
  - word access with addr_i[1:0] != 0.
- access_fault_o = (state == IDLE) & access & fault.
  - A faulting access issues no request and does not stall.
  - readMem_o is loaded with 0 at the next edge.
- FSM, rising edge:
  - IDLE: if access & !fault, go to REQ; counter = 0.
  - REQ:
    - dmem_req_o = 1; dmem_we_o, dmem_be_o, dmem_addr_o and dmem_wdata_o are held stable from the inputs, which are frozen by the stall.
    - If dmem_ack_i: for a load, readMem_o <= formatted dmem_rdata_i; for a store, readMem_o is unchanged. Go to DONE.
    - Else if counter == TIMEOUT_CYCLES-1: timeout_o <= 1, readMem_o <= 0, go to DONE.
    - Else counter++.
    - If ack arrives in the timeout cycle, ack wins.
  - DONE: always go to IDLE. This is one cycle; the pipeline advances at its end, and MEM/WB samples readMem_o at the falling edge inside DONE.
- stall_o = (IDLE & access & !fault) | REQ. It is 0 in DONE.
- dmem_req_o is 0 in IDLE and DONE. Minimum access latency is 3 cycles (IDLE detect, REQ with ack, DONE).
- Store lanes, with o = addr_i[1:0]:
  - SB: be = 4'b0001 << o; wdata = {4{wdata_i[7:0]}}.
  - SH: be = o[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata_i[15:0]}}.
  - SW: be = 4'b1111; wdata = wdata_i.
- Loads: be = 4'b1111. Formatting:
  - LB/LBU select byte o and sign-/zero-extend it.
  - LH/LHU select half o[1] and sign-/zero-extend it.
  - LW passes the word through.

Test Plan:
- LW, addr 0x100, ack after 2 REQ cycles with rdata 0x12345678 -> stall_o high 3 cycles; dmem_addr_o 0x100; be 1111; readMem_o 0x12345678 in DONE; stall_o 0 in DONE.
- LB at 0x103 and LBU at 0x103, rdata 0x80FF7F01 -> readMem_o 0xFFFFFF80, then 0x00000080.
- SH at 0x0A2, wdata_i 0x0000BEEF, immediate ack -> dmem_we_o 1; be 1100; dmem_wdata_o 0xBEEFBEEF; readMem_o unchanged.
- LW at 0x101, and a second case with mem_read_i & mem_write_i both set -> access_fault_o 1; dmem_req_o never asserted; stall_o 0; readMem_o 0.
- LW with no ack, TIMEOUT_CYCLES=4 -> dmem_req_o high exactly 4 cycles; timeout_o set and sticky; readMem_o 0; then ack arriving exactly in the 4th cycle on a retry -> completes normally.
- rst pulsed mid-REQ -> dmem_req_o, stall_o and readMem_o go to 0 immediately; state IDLE; a new LW after reset completes normally.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM-stage access unit and a word-organised
// data memory. One request/acknowledge handshake carries a single access.
//   req   : access request, held until ack or abandon
//   we    : 1 = write
//   addr  : word address (low two bits always 0)
//   be    : byte enables, bit n enables byte lane n
//   wdata : lane-replicated store data
//   ack   : completion; rdata is valid in the same cycle
//   rdata : read word
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit. Takes load/store controls from EX/MEM,
// runs one req/ack transaction on the data-memory bus, formats the load
// result for MEM/WB and stalls the upstream pipeline while busy.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   mem_read_i/_write_i, funct3_i, addr_i, wdata_i : access from EX/MEM
//   dmem            : data-memory bus (master side)
//   readMem_o       : registered, formatted load result
//   stall_o         : freeze PC/IF/ID/EX/MEM registers
//   access_fault_o  : misaligned or illegal access seen in IDLE
//   timeout_o       : sticky, set when an access is abandoned
//
// state | meaning
// IDLE  | waiting for an access; faulting accesses are rejected here
// REQ   | request on the bus, waiting for ack or timeout
// DONE  | result available for one cycle, pipeline advances at its end
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_read_i,
  input  logic                        mem_write_i,
  input  logic [2:0]                  funct3_i,
  input  logic [31:0]                 addr_i,
  input  logic [31:0]                 wdata_i,
  mem_access_stage_if.master          dmem,
  output logic [31:0]                 readMem_o,
  output logic                        stall_o,
  output logic                        access_fault_o,
  output logic                        timeout_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       read_mem_q, read_mem_d;
  logic              timeout_q, timeout_d;

  logic        access;
  logic        legal_ld;
  logic        legal_st;
  logic        misaligned;
  logic        fault;
  logic [1:0]  offs;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic [3:0]  be;
  logic [31:0] wdata;

  assign access = mem_read_i | mem_write_i;
  assign offs   = addr_i[1:0];

  always_comb begin
    legal_ld   = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                 (funct3_i == 3'b100) || (funct3_i == 3'b101);
    legal_st   = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
    // funct3[1:0] encodes the size for every legal load/store
    misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (offs != 2'b00));
    fault      = (mem_read_i && mem_write_i) ||
                 (mem_read_i && !legal_ld) ||
                 (mem_write_i && !legal_st) ||
                 misaligned;
  end

  always_comb begin
    be    = 4'b1111;
    wdata = wdata_i;
    if (mem_write_i) begin
      case (funct3_i[1:0])
        2'b00: begin
          be    = 4'b0001 << offs;
          wdata = {4{wdata_i[7:0]}};
        end
        2'b01: begin
          be    = offs[1] ? 4'b1100 : 4'b0011;
          wdata = {2{wdata_i[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    case (offs)
      2'd0:    ld_byte = dmem.rdata[7:0];
      2'd1:    ld_byte = dmem.rdata[15:8];
      2'd2:    ld_byte = dmem.rdata[23:16];
      default: ld_byte = dmem.rdata[31:24];
    endcase
    ld_half = offs[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (funct3_i)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = dmem.rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    read_mem_d = read_mem_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (access && !fault) begin
          state_d = REQ;
          cnt_d   = '0;
        end else if (access) begin
          read_mem_d = '0;
        end
      end
      REQ: begin
        // ack in the final timeout cycle still completes the access
        if (dmem.ack) begin
          if (mem_read_i) read_mem_d = ld_fmt;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d  = 1'b1;
          read_mem_d = '0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      read_mem_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      read_mem_q <= read_mem_d;
      timeout_q  <= timeout_d;
    end
  end

  assign dmem.req       = (state_q == REQ);
  assign dmem.we        = mem_write_i;
  assign dmem.addr      = {addr_i[31:2], 2'b00};
  assign dmem.be        = be;
  assign dmem.wdata     = wdata;
  assign readMem_o      = read_mem_q;
  assign timeout_o      = timeout_q;
  assign access_fault_o = (state_q == IDLE) && access && fault;
  // Held low during reset so a pending access cannot freeze the pipeline.
  assign stall_o        = !rst && (((state_q == IDLE) && access && !fault) || (state_q == REQ));

endmodule
